// File: rtl/tt_sweep_pkg.sv
// ============================================================================
// Module : tt_sweep_pkg
// Brief  : Shared types and helpers for the tt_sweep truth-table sweeper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tt_sweep_pkg;

    localparam int MAX_N_IN = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Width of a counter that must hold values up to hold_cyc.
    function automatic int hold_cnt_w(input int hold_cyc);
        return $clog2(hold_cyc + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_hold_timer.sv
// ============================================================================
// Module : tt_hold_timer
// Brief  : Per-vector hold counter, 0..HOLD_CYC-1, strobing on the last cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tt_hold_timer
    import tt_sweep_pkg::*;
#(
    parameter int HOLD_CYC = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int            CW     = hold_cnt_w(HOLD_CYC);
    localparam logic [CW-1:0] C_LAST = CW'(HOLD_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign last = en && (cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/tt_sweep.sv
// ============================================================================
// Module : tt_sweep
// Brief  : Exhaustive truth-table sweeper with mismatch count and pass flag.
//          Optional first-failure capture with TT_SWEEP_FIRSTFAIL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int                  N_IN     = 4,
    parameter int                  HOLD_CYC = 20,
    parameter logic [2**N_IN-1:0]  EXP_TT   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            gray,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   err_cnt,
    output logic            pass
`ifdef TT_SWEEP_FIRSTFAIL_EN
    ,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_vld
`endif
);

    localparam logic [N_IN-1:0] IDX_MAX = {N_IN{1'b1}};

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] idx;
    logic [N_IN-1:0] vec_r;
    logic            gray_mode;
    logic [N_IN:0]   err_r;
    logic            pass_r;
    logic            last;
    logic            start_acc;
    logic            sample;
    logic            mismatch;
    logic            idx_last;

    function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i, input logic g);
        return g ? N_IN'(bin2gray(MAX_N_IN'(i))) : i;
    endfunction

    tt_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .en    (busy),
        .last  (last)
    );

    assign start_acc = (state == ST_IDLE) && start;
    // An abort in the sampling cycle discards that sample.
    assign sample    = (state == ST_DRIVE) && last && !abort;
    assign mismatch  = (dut_out != EXP_TT[vec_r]);
    assign idx_last  = (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last && idx_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            vec_r     <= '0;
            gray_mode <= 1'b0;
            err_r     <= '0;
            pass_r    <= 1'b0;
        end else if (start_acc) begin
            idx       <= '0;
            vec_r     <= '0;
            gray_mode <= gray;
            err_r     <= '0;
            pass_r    <= 1'b0;
        end else if (sample) begin
            if (mismatch) begin
                err_r <= err_r + 1'b1;
            end
            // Pass is resolved with the final sample so it is valid in the done cycle.
            if (idx_last) begin
                pass_r <= (err_r == '0) && !mismatch;
            end else begin
                idx   <= idx + 1'b1;
                vec_r <= map_vec(idx + 1'b1, gray_mode);
            end
        end
    end

`ifdef TT_SWEEP_FIRSTFAIL_EN
    logic [N_IN-1:0] ff_vec_r;
    logic            ff_vld_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vec_r <= '0;
            ff_vld_r <= 1'b0;
        end else if (start_acc) begin
            ff_vec_r <= '0;
            ff_vld_r <= 1'b0;
        end else if (sample && mismatch && !ff_vld_r) begin
            ff_vec_r <= vec_r;
            ff_vld_r <= 1'b1;
        end
    end

    assign first_fail_vec = ff_vec_r;
    assign first_fail_vld = ff_vld_r;
`endif

    assign vec     = vec_r;
    assign busy    = (state == ST_DRIVE);
    assign done    = (state == ST_DONE);
    assign err_cnt = err_r;
    assign pass    = pass_r;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep.sv
// ============================================================================
// Module : tb_tt_sweep
// Brief  : Self-checking bench for tt_sweep against an elapsed-time model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tt_sweep;

    localparam int          N_IN     = 4;
    localparam int          HOLD_CYC = 2;
    localparam int          NV       = 16;
    localparam logic [15:0] EXP_TT   = 16'hA5C3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        gray  = 1'b0;
    logic        dut_out;
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic [4:0]  err_cnt;
    logic        pass;
`ifdef TT_SWEEP_FIRSTFAIL_EN
    logic [3:0]  first_fail_vec;
    logic        first_fail_vld;
`endif

    logic [15:0] exp_tt = EXP_TT;
    logic [15:0] flip   = '0;
    logic [3:0]  gseq [16];
    int          tests  = 0;
    int          fails  = 0;
    int          done_seen = 0;

    always #5 clk = ~clk;

    // Stand-in combinational DUT: truth table with selected vectors inverted.
    assign dut_out = exp_tt[vec] ^ flip[vec];

    tt_sweep #(
        .N_IN     (N_IN),
        .HOLD_CYC (HOLD_CYC),
        .EXP_TT   (EXP_TT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .gray           (gray),
        .dut_out        (dut_out),
        .vec            (vec),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .pass           (pass)
`ifdef TT_SWEEP_FIRSTFAIL_EN
        ,
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: elapsed cycles since start decide vector and sample points.
    logic       m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_fin = 1'b0;
    logic       m_gray = 1'b0, m_ffvld = 1'b0;
    logic [3:0] m_vec = '0, m_ffv = '0;
    int         m_k = 0, m_err = 0;

    function automatic logic [3:0] vmap(input int j, input logic g);
        logic [3:0] b;
        b = 4'(j);
        return g ? (b ^ (b >> 1)) : b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_pass = 0; m_gray = 0;
            m_vec = 0; m_k = 0; m_err = 0; m_ffv = 0; m_ffvld = 0;
        end else begin
            m_fin = 0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 0;
                end else begin
                    if (m_k % HOLD_CYC == HOLD_CYC - 1) begin
                        if (flip[m_vec]) begin
                            m_err++;
                            if (!m_ffvld) begin m_ffvld = 1; m_ffv = m_vec; end
                        end
                        if (m_k / HOLD_CYC == NV - 1) begin
                            m_busy = 0; m_fin = 1; m_pass = (m_err == 0);
                        end
                    end
                    m_k++;
                    if (m_busy) m_vec = vmap(m_k / HOLD_CYC, m_gray);
                end
            end else if (!m_done && start) begin
                m_busy = 1; m_k = 0; m_vec = 0; m_err = 0; m_pass = 0;
                m_gray = gray; m_ffv = 0; m_ffvld = 0;
            end
            m_done = m_fin;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_seen++;
            chk("vec", 32'(vec), 32'(m_vec));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            chk("pass", 32'(pass), 32'(m_pass));
`ifdef TT_SWEEP_FIRSTFAIL_EN
            chk("ff_vec", 32'(first_fail_vec), 32'(m_ffv));
            chk("ff_vld", 32'(first_fail_vld), 32'(m_ffvld));
`endif
        end
    end

    // One sweep: cycle c=1 is the first cycle after the start edge.
    task automatic run_sweep(input logic g, input logic ab0, input int abort_at,
                             input int rs_a, input int rs_b, input int rst_at,
                             output int done_at, output int busy_fall);
        done_at   = -1;
        busy_fall = -1;
        @(negedge clk);
        start = 1'b1; gray = g; abort = ab0;
        @(negedge clk);
        start = 1'b0; gray = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done && done_at < 0) done_at = c;
            if (!busy && busy_fall < 0) busy_fall = c;
            if (c <= HOLD_CYC * NV && (c - 1) % HOLD_CYC == 0) gseq[(c - 1) / HOLD_CYC] = vec;
            if (c == rst_at + 1) rst_n = 1'b1;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_vec", 32'(vec), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_err", 32'(err_cnt), 0);
                chk("rst_pass", 32'(pass), 0);
            end
            abort = (c == abort_at);
            start = (c == rs_a) || (c == rs_b);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int da, bf, ab_at, rs, ds;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("init_vec", 32'(vec), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_done", 32'(done), 0);
        chk("init_err", 32'(err_cnt), 0);
        chk("init_pass", 32'(pass), 0);

        // Matching DUT, binary order.
        flip = '0;
        run_sweep(1'b0, 1'b0, -1, -1, -1, -1, da, bf);
        chk("bin_done_at", 32'(da), 33);
        chk("bin_busy_fall", 32'(bf), 33);
        chk("bin_err", 32'(err_cnt), 0);
        chk("bin_pass", 32'(pass), 1);
        for (int k = 0; k < 16; k++) chk("bin_seq", 32'(gseq[k]), 32'(k));

        // Single inverted vector 5.
        flip = 16'h0020;
        run_sweep(1'b0, 1'b0, -1, -1, -1, -1, da, bf);
        chk("one_err", 32'(err_cnt), 1);
        chk("one_pass", 32'(pass), 0);
        chk("one_model_err", 32'(m_err), 1);
`ifdef TT_SWEEP_FIRSTFAIL_EN
        chk("one_ff_vec", 32'(first_fail_vec), 5);
        chk("one_ff_vld", 32'(first_fail_vld), 1);
`endif

        // Gray order; start and abort together in IDLE (start wins).
        flip = '0;
        run_sweep(1'b1, 1'b1, -1, -1, -1, -1, da, bf);
        chk("gray_done_at", 32'(da), 33);
        chk("gray_seq0", 32'(gseq[0]), 0);
        chk("gray_seq1", 32'(gseq[1]), 1);
        chk("gray_seq2", 32'(gseq[2]), 3);
        chk("gray_seq3", 32'(gseq[3]), 2);
        chk("gray_seq4", 32'(gseq[4]), 6);
        chk("gray_seq5", 32'(gseq[5]), 7);
        chk("gray_seq6", 32'(gseq[6]), 5);
        chk("gray_seq7", 32'(gseq[7]), 4);
        chk("gray_seq15", 32'(gseq[15]), 8);
        chk("gray_pass", 32'(pass), 1);

        // Abort at cycle 10 with every vector wrong.
        flip = 16'hFFFF;
        ds = done_seen;
        run_sweep(1'b0, 1'b0, 10, -1, -1, -1, da, bf);
        chk("abort_busy_fall", 32'(bf), 11);
        chk("abort_no_done", 32'(da), 32'(-1));
        chk("abort_done_cnt", 32'(done_seen - ds), 0);
        chk("abort_err", 32'(err_cnt), 4);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_model_err", 32'(m_err), 4);

        // Restart pulses while busy are ignored.
        flip = '0;
        run_sweep(1'b0, 1'b0, -1, 5, 20, -1, da, bf);
        chk("restart_done_at", 32'(da), 33);
        chk("restart_pass", 32'(pass), 1);

        // Reset mid-sweep, then a full sweep from vec 0.
        flip = 16'h8001;
        run_sweep(1'b0, 1'b0, -1, -1, -1, 7, da, bf);
        chk("rst_no_done", 32'(da), 32'(-1));
        run_sweep(1'b0, 1'b0, -1, -1, -1, -1, da, bf);
        chk("post_rst_done_at", 32'(da), 33);
        chk("post_rst_seq0", 32'(gseq[0]), 0);
        chk("post_rst_err", 32'(err_cnt), 2);

        // Randomized sweeps, checked every cycle by the model.
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 100 && (busy || done); w++) @(negedge clk);
            flip  = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1;
            rs    = int'($urandom_range(1, 33));
            run_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab_at, rs, -1, -1, da, bf);
        end
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
